stream_seq_checker: RTL

Single-clock stream sink that sits on the read side of the async FIFO, or any valid/ready stream. It drives programmable backpressure on ready and checks that the received data is a mod-2^DataWidth incrementing sequence. It counts accepted beats and sequence errors, and captures the first-error context for bench or debug readout. It pairs with the incrementing-data writer used on the FIFO write side.

---
 rtl/stream_chk_pkg.sv | 24 ++
 rtl/lfsr16.sv | 29 ++
 rtl/stream_seq_checker.sv | 137 +++++++++++++
 3 files changed

// File: rtl/stream_chk_pkg.sv
// Shared types and constants for the stream sequence checker and its LFSR.
package stream_chk_pkg;

   typedef enum logic [1:0] {
      BP_ALWAYS = 2'd0,
      BP_RANDOM = 2'd1,
      BP_NEVER  = 2'd2
   } bp_mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } chk_state_e;

   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
   // Feedback taps b0,b2,b3,b5 for x^16+x^14+x^13+x^11+1 in a right-shifting register
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, right-shifting, with synchronous reload and advance enable.
module lfsr16
   import stream_chk_pkg::*;
#(
   parameter logic [15:0] ResetVal = LFSR_SEED_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        advance,
   input  logic [15:0] seed,
   output logic [15:0] out
);

   logic [15:0] r_lfsr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lfsr <= ResetVal;
      end else if (clear) begin
         r_lfsr <= seed;
      end else if (advance) begin
         r_lfsr <= lfsr16_step(r_lfsr);
      end
   end

   assign out = r_lfsr;

endmodule

// File: rtl/stream_seq_checker.sv
// Valid/ready stream sink: programmable backpressure, incrementing-sequence check,
// saturating beat/error counters and first-error capture.
module stream_seq_checker
   import stream_chk_pkg::*;
#(
   parameter int          DataWidth = 4,
   parameter int          CntWidth  = 32,
   parameter logic [15:0] LfsrSeed  = LFSR_SEED_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 clear,
   input  logic [1:0]           bp_mode,
   input  logic                 in_valid,
   input  logic [DataWidth-1:0] in_data,
   output logic                 in_ready,
   output logic                 locked,
   output logic [CntWidth-1:0]  rx_count,
   output logic [CntWidth-1:0]  err_count,
   output logic                 err_flag,
   output logic [DataWidth-1:0] first_exp,
   output logic [DataWidth-1:0] first_got
);

   localparam logic [CntWidth-1:0] CntMax = '1;

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
      return (c == CntMax) ? c : c + 1'b1;
   endfunction

   chk_state_e           r_state;
   logic [DataWidth-1:0] r_exp;
   logic                 r_ready;
   logic [CntWidth-1:0]  r_rx;
   logic [CntWidth-1:0]  r_err;
   logic                 r_flag;
   logic [DataWidth-1:0] r_fexp;
   logic [DataWidth-1:0] r_fgot;

   logic [15:0] w_lfsr;
   logic        w_lfsr_nxt0;
   logic        w_lfsr_unused;
   logic        w_ready_nxt;
   logic        w_acc;

   lfsr16 #(.ResetVal(LfsrSeed)) u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .advance (enable),
      .seed    (LfsrSeed),
      .out     (w_lfsr)
   );

   // Ready is registered, so it follows bit 0 of the LFSR value after this edge's shift.
   assign w_lfsr_nxt0   = clear ? LfsrSeed[0] : w_lfsr[1];
   assign w_lfsr_unused = ^{w_lfsr[15:2], w_lfsr[0]};
   assign w_acc         = in_valid & r_ready;

   always_comb begin
      w_ready_nxt = 1'b0;
      if (enable) begin
         case (bp_mode)
            BP_ALWAYS: w_ready_nxt = 1'b1;
            BP_RANDOM: w_ready_nxt = w_lfsr_nxt0;
            BP_NEVER:  w_ready_nxt = 1'b0;
            default:   w_ready_nxt = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_ready <= 1'b0;
         r_rx    <= '0;
         r_err   <= '0;
         r_flag  <= 1'b0;
         r_fexp  <= '0;
         r_fgot  <= '0;
      end else if (clear) begin
         r_state <= enable ? SYNC : IDLE;
         r_ready <= w_ready_nxt;
         r_rx    <= '0;
         r_err   <= '0;
         r_flag  <= 1'b0;
         r_fexp  <= '0;
         r_fgot  <= '0;
      end else begin
         r_ready <= w_ready_nxt;
         if (!enable) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: r_state <= SYNC;
               SYNC: begin
                  if (w_acc) begin
                     r_rx    <= sat_inc(r_rx);
                     r_state <= LOCKED;
                  end
               end
               LOCKED: begin
                  if (w_acc) begin
                     r_rx <= sat_inc(r_rx);
                     if (in_data != r_exp) begin
                        r_err <= sat_inc(r_err);
                        if (!r_flag) begin
                           r_flag <= 1'b1;
                           r_fexp <= r_exp;
                           r_fgot <= in_data;
                        end
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // Expected value is only meaningful once SYNC has loaded it, so it carries no reset.
   always_ff @(posedge clk) begin
      if (!clear && enable && w_acc && (r_state != IDLE)) begin
         r_exp <= in_data + 1'b1;
      end
   end

   assign in_ready  = r_ready;
   assign locked    = (r_state == LOCKED);
   assign rx_count  = r_rx;
   assign err_count = r_err;
   assign err_flag  = r_flag;
   assign first_exp = r_fexp;
   assign first_got = r_fgot;

endmodule
